ifu_fetch: RTL and testbench

- Instruction fetch unit. Produces the 32-bit instruction words that the decoder consumes.
- Owns the PC and issues word reads on a valid/ready instruction-memory port.
- Buffers returned words with their PCs in a small FIFO and presents them to decode on a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush, and a halt input driven by ebreak.

---
 rtl/rv_pkg.sv | 13 +
 rtl/ifu_fifo.sv | 46 ++++
 rtl/ifu_fetch.sv | 91 +++++++++
 tb/tb_ifu_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-side types: fetch FSM states and the FIFO entry layout.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Small circular FIFO holding fetched {pc, inst} entries; flush wins over push/pop.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_rd, r_wr;
  logic [CW-1:0]           r_count;
  logic                    w_pop;

  assign w_pop = pop && (r_count != '0);
  assign head  = r_mem[r_rd];
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_mem   <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!push && w_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one word read at a time, buffers
// returned words for decode, and handles redirect/flush and halt.
module ifu_fetch import rv_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state, w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_addr;  // also the PC of the in-flight request
  logic          r_drop;
  logic [CW-1:0] w_count;
  logic [31:0]   w_redir_pc;
  logic          w_issue, w_push;
  fetch_entry_t  w_push_entry, w_head;

  assign w_redir_pc   = redirect_pc & ~32'h3;
  assign w_issue      = !halt && (w_count < CW'(DEPTH));
  // A response racing a redirect belongs to the old stream, so it is dropped.
  assign w_push       = (r_state == WAIT) && imem_rsp_valid && !r_drop && !redirect_valid;
  assign w_push_entry = '{pc: r_req_addr, inst: imem_rsp_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue)        w_state_nxt = REQ;
      REQ:     if (imem_req_ready) w_state_nxt = WAIT;
      WAIT:    if (imem_rsp_valid) w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_issue)
        r_req_addr <= redirect_valid ? w_redir_pc : r_pc;
      if (redirect_valid)
        r_pc <= w_redir_pc;
      else if (w_push)
        r_pc <= r_req_addr + 32'd4;
      // Redirect during REQ marks the still-pending request as stale.
      case (r_state)
        REQ:     if (redirect_valid) r_drop <= 1'b1;
        WAIT:    if (imem_rsp_valid) r_drop <= 1'b0;
                 else if (redirect_valid) r_drop <= 1'b1;
        default: ;
      endcase
    end
  end

  ifu_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .head      (w_head),
    .count     (w_count)
  );

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = (w_count != '0);
  assign inst           = w_head.inst;
  assign inst_pc        = w_head.pc;
  assign busy           = (r_state != IDLE) || (w_count != '0);
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: random memory/decode/redirect traffic plus directed
// scenarios, checked against a sequential-PC stream model.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .busy(busy)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int p_ready = 100, p_instr = 100, p_redir = 0, p_halt = 0, dmin = 0, dmax = 0;
  logic [31:0] mem_q[$];
  int          mem_wait = 0;
  logic [31:0] exp_pc = RST_PC;
  int          n_acc = 0, n_del = 0;
  logic [31:0] last_acc = '0;
  logic        exp_acc_v = 1'b0;
  logic [31:0] exp_acc = '0;
  logic        force_redir = 1'b0, redir_on_rsp = 1'b0, stale_rsp = 1'b0;
  logic [31:0] ov_pc = '0;
  logic        prev_req_v = 1'b0, prev_halt = 1'b0, prev_rst = 1'b0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    if (a == 32'h8000_0004) return 32'h0020_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid",  {31'b0, imem_req_valid}, 0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 0);
    chk("rst_busy",       {31'b0, busy}, 0);
    chk("rst_req_addr",   imem_req_addr, RST_PC);
    chk("rst_inst",       inst, 0);
    chk("rst_inst_pc",    inst_pc, 0);
  endtask

  // One clock: drive inputs, sample pre-edge, advance, update the model.
  task automatic step();
    logic s_rv, s_rr, s_sv, s_iv, s_ir, s_rd, s_h, s_rst, s_stale;
    logic [31:0] s_addr, s_ipc, s_inst, s_rpc;
    imem_req_ready = ($urandom_range(99) < p_ready);
    s_stale = stale_rsp;
    if (stale_rsp) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; stale_rsp = 1'b0;
    end else if (mem_q.size() != 0 && mem_wait == 0) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = memfn(mem_q[0]);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    inst_ready     = ($urandom_range(99) < p_instr);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = ov_pc; force_redir = 1'b0;
    end
    if (redir_on_rsp && imem_rsp_valid && inst_valid) begin
      redirect_valid = 1'b1; redirect_pc = ov_pc; inst_ready = 1'b1; redir_on_rsp = 1'b0;
    end
    if ($urandom_range(99) < p_halt) halt = ~halt;
    #1;
    s_rv = imem_req_valid; s_rr = imem_req_ready; s_addr = imem_req_addr;
    s_sv = imem_rsp_valid; s_iv = inst_valid; s_ir = inst_ready;
    s_ipc = inst_pc; s_inst = inst; s_rd = redirect_valid; s_rpc = redirect_pc;
    s_h = halt; s_rst = rst_n;
    if (s_rv === 1'b1) chk("req_addr_align", {30'b0, s_addr[1:0]}, 0);
    if (s_rst && dut.w_push === 1'b1) chk("push_not_full", {31'b0, dut.w_count < DEPTH}, 1);
    if (prev_halt && prev_rst && s_rst) chk("halt_no_issue", {31'b0, s_rv && !prev_req_v}, 0);

    @(posedge clk); #1;
    if (!s_rst) begin
      mem_q.delete(); mem_wait = 0; exp_pc = RST_PC;
    end else begin
      if (s_sv && !s_stale && mem_q.size() != 0) void'(mem_q.pop_front());
      if (s_rv && s_rr) begin
        chk("one_outstanding", mem_q.size(), 0);
        mem_q.push_back(s_addr);
        mem_wait = $urandom_range(dmax, dmin);
        n_acc++; last_acc = s_addr;
        if (exp_acc_v) begin chk("next_req_addr", s_addr, exp_acc); exp_acc_v = 1'b0; end
      end else if (mem_wait > 0) mem_wait--;
      if (s_rv && !s_rr) begin
        chk("req_hold_valid", {31'b0, imem_req_valid}, 1);
        chk("req_hold_addr", imem_req_addr, s_addr);
      end
      if (s_iv && s_ir && !s_rd) begin
        chk("inst_pc", s_ipc, exp_pc);
        chk("inst_data", s_inst, memfn(exp_pc));
        exp_pc += 32'd4; n_del++;
      end
      if (s_rd) exp_pc = s_rpc & ~32'h3;
    end
    prev_req_v = s_rv; prev_halt = s_h; prev_rst = s_rst;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    chk_reset_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int n0, n1;
    // A: reset values, then zero-wait streaming from RESET_PC
    do_reset(2);
    n0 = n_del;
    repeat (20) step();
    chk("A_progress", {31'b0, (n_del - n0) >= 3}, 1);

    // B: decode stalled -> exactly DEPTH fetches, then resume at +8
    p_instr = 0;
    do_reset(1);
    n0 = n_acc;
    repeat (15) step();
    chk("B_acc_count", n_acc - n0, DEPTH);
    chk("B_last_acc", last_acc, 32'h8000_0004);
    chk("B_req_idle", {31'b0, imem_req_valid}, 0);
    chk("B_inst_valid", {31'b0, inst_valid}, 1);
    chk("B_busy", {31'b0, busy}, 1);
    exp_acc = 32'h8000_0008; exp_acc_v = 1'b1; p_instr = 100;
    repeat (10) step();
    chk("B_resume", {31'b0, exp_acc_v}, 0);

    // C: redirect while waiting on 0x80000004
    dmin = 3; dmax = 3;
    do_reset(1);
    n0 = n_acc;
    for (int i = 0; i < 60 && (n_acc - n0) < 2; i++) step();
    chk("C_in_wait", last_acc, 32'h8000_0004);
    ov_pc = 32'h8000_0103; force_redir = 1'b1;
    exp_acc = 32'h8000_0100; exp_acc_v = 1'b1;
    step();
    chk("C_flushed", {31'b0, inst_valid}, 0);
    n1 = n_del;
    repeat (30) step();
    chk("C_next_req", {31'b0, exp_acc_v}, 0);
    chk("C_delivered", {31'b0, n_del > n1}, 1);

    // D: redirect together with a response and a pop
    dmin = 2; dmax = 2; p_instr = 0;
    do_reset(1);
    ov_pc = 32'h8000_0200; redir_on_rsp = 1'b1;
    for (int i = 0; i < 40 && redir_on_rsp; i++) step();
    chk("D_triggered", {31'b0, redir_on_rsp}, 0);
    chk("D_empty", {31'b0, inst_valid}, 0);
    chk("D_busy", {31'b0, busy}, 0);
    exp_acc = 32'h8000_0200; exp_acc_v = 1'b1; p_instr = 100;
    repeat (20) step();
    chk("D_next_req", {31'b0, exp_acc_v}, 0);

    // E: halt with a request outstanding
    do_reset(1);
    n0 = n_acc;
    for (int i = 0; i < 60 && !((n_acc - n0) >= 3 && mem_q.size() != 0); i++) step();
    chk("E_outstanding", mem_q.size(), 1);
    halt = 1'b1; n1 = n_del;
    repeat (30) step();
    chk("E_delivered", {31'b0, n_del > n1}, 1);
    chk("E_busy", {31'b0, busy}, 0);
    chk("E_req_idle", {31'b0, imem_req_valid}, 0);
    chk("E_fifo_empty", {31'b0, inst_valid}, 0);
    exp_acc = exp_pc; exp_acc_v = 1'b1; halt = 1'b0;
    repeat (15) step();
    chk("E_resume", {31'b0, exp_acc_v}, 0);

    // F: one-cycle reset during WAIT, then a stale response
    dmin = 3; dmax = 3;
    do_reset(1);
    n0 = n_acc;
    for (int i = 0; i < 60 && !((n_acc - n0) >= 2 && mem_wait >= 2); i++) step();
    chk("F_in_wait", {31'b0, mem_wait >= 2}, 1);
    do_reset(1);
    stale_rsp = 1'b1; exp_acc = RST_PC; exp_acc_v = 1'b1; n1 = n_del;
    repeat (25) step();
    chk("F_first_req", {31'b0, exp_acc_v}, 0);
    chk("F_delivered", {31'b0, n_del > n1}, 1);

    // G: random traffic with redirects (incl. near wrap) and halt toggling
    p_ready = 70; p_instr = 70; p_redir = 3; p_halt = 2; dmin = 0; dmax = 3;
    n1 = n_del;
    repeat (3000) step();
    p_halt = 0; p_redir = 0; halt = 1'b0;
    repeat (30) step();
    chk("G_progress", {31'b0, (n_del - n1) > 100}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
